// File: rtl/req_queue_pkg.sv
// Shared constants for the two-client request queue: default sizes,
// source tags and the occupancy counter width rule.
package req_queue_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    localparam logic SRC_0 = 1'b0;
    localparam logic SRC_1 = 1'b1;

    // One extra bit so the counter can hold DEPTH itself (0..DEPTH inclusive).
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Single-clock FIFO with occupancy count and a sticky overflow flag
// for pushes dropped while full.
module req_fifo
    import req_queue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              ovf
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && full) begin
                ovf <= 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/req_queue.sv
// Arbiter front-end: two client FIFOs raise requests, and each qualified
// grant pops one word onto a shared registered output tagged by source.
module req_queue
    import req_queue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              wr_en_0,
    input  logic [DATA_W-1:0] wr_data_0,
    input  logic              wr_en_1,
    input  logic [DATA_W-1:0] wr_data_1,
    input  logic              sig_0,
    input  logic              sig_1,
    output logic              req_0,
    output logic              req_1,
    output logic              full_0,
    output logic              full_1,
    output logic [CNT_W-1:0]  count_0,
    output logic [CNT_W-1:0]  count_1,
    output logic              ovf_0,
    output logic              ovf_1,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src
);

    logic              empty_0;
    logic              empty_1;
    logic [DATA_W-1:0] head_0;
    logic [DATA_W-1:0] head_1;
    logic              pop_0_p0;
    logic              pop_1_p0;

    assign req_0 = !empty_0;
    assign req_1 = !empty_1;

    // Client 0 wins an illegal double grant; sig_1 is ignored that cycle.
    assign pop_0_p0 = sig_0 && req_0;
    assign pop_1_p0 = sig_1 && req_1 && !pop_0_p0;

    req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_0 (
        .clk     (clk),
        .rst     (rest),
        .push    (wr_en_0),
        .pop     (pop_0_p0),
        .data_in (wr_data_0),
        .head    (head_0),
        .count   (count_0),
        .full    (full_0),
        .empty   (empty_0),
        .ovf     (ovf_0)
    );

    req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_1 (
        .clk     (clk),
        .rst     (rest),
        .push    (wr_en_1),
        .pop     (pop_1_p0),
        .data_in (wr_data_1),
        .head    (head_1),
        .count   (count_1),
        .full    (full_1),
        .empty   (empty_1),
        .ovf     (ovf_1)
    );

    // Stage p0 -> p1: popped word is registered onto the shared output.
    always_ff @(posedge clk) begin
        if (rest) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= SRC_0;
        end else if (pop_0_p0) begin
            out_valid <= 1'b1;
            out_data  <= head_0;
            out_src   <= SRC_0;
        end else if (pop_1_p0) begin
            out_valid <= 1'b1;
            out_data  <= head_1;
            out_src   <= SRC_1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_req_queue.sv
// Directed bench for req_queue: a per-cycle vector table plus a
// pointer-wrap sequence with back-to-back push and pop.
module tb_req_queue;

    logic       clk = 1'b0;
    logic       rest;
    logic       wr_en_0, wr_en_1, sig_0, sig_1;
    logic [7:0] wr_data_0, wr_data_1;
    logic       req_0, req_1, full_0, full_1, ovf_0, ovf_1;
    logic [2:0] count_0, count_1;
    logic       out_valid, out_src;
    logic [7:0] out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    req_queue #(.DATA_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rest      (rest),
        .wr_en_0   (wr_en_0),
        .wr_data_0 (wr_data_0),
        .wr_en_1   (wr_en_1),
        .wr_data_1 (wr_data_1),
        .sig_0     (sig_0),
        .sig_1     (sig_1),
        .req_0     (req_0),
        .req_1     (req_1),
        .full_0    (full_0),
        .full_1    (full_1),
        .count_0   (count_0),
        .count_1   (count_1),
        .ovf_0     (ovf_0),
        .ovf_1     (ovf_1),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    typedef struct {
        logic       rst, we0;
        logic [7:0] d0;
        logic       we1;
        logic [7:0] d1;
        logic       g0, g1;
        logic [2:0] c0, c1;
        logic       v;
        logic [7:0] od;
        logic       os, ovf0, ovf1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, we0, input logic [7:0] d0,
                       input logic we1, input logic [7:0] d1,
                       input logic g0, g1, input logic [2:0] c0, c1,
                       input logic v, input logic [7:0] od,
                       input logic os, ovf0, ovf1);
        vec_t r;
        r = '{rst, we0, d0, we1, d1, g0, g1, c0, c1, v, od, os, ovf0, ovf1};
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, we0, input logic [7:0] d0,
                         input logic we1, input logic [7:0] d1, input logic g0, g1);
        rest = rst; wr_en_0 = we0; wr_data_0 = d0;
        wr_en_1 = we1; wr_data_1 = d1; sig_0 = g0; sig_1 = g1;
    endtask

    initial begin
        //   rst we0 d0     we1 d1     g0 g1  c0 c1 v  od     os ovf0 ovf1
        add(1, 1, 8'hAA, 0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 0, 0, 0);
        add(1, 1, 8'hAA, 0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'hA5, 0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 0, 0, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 1, 8'hA5, 0, 0, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 8'hA5, 0, 0, 0);
        add(0, 0, 8'h00, 1, 8'h01, 0, 0,  0, 1, 0, 8'hA5, 0, 0, 0);
        add(0, 0, 8'h00, 1, 8'h02, 0, 0,  0, 2, 0, 8'hA5, 0, 0, 0);
        add(0, 0, 8'h00, 1, 8'h03, 0, 0,  0, 3, 0, 8'hA5, 0, 0, 0);
        add(0, 0, 8'h00, 1, 8'h04, 0, 0,  0, 4, 0, 8'hA5, 0, 0, 0);
        add(0, 0, 8'h00, 1, 8'h05, 0, 0,  0, 4, 0, 8'hA5, 0, 0, 1);
        add(0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 3, 1, 8'h01, 1, 0, 1);
        add(0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 2, 1, 8'h02, 1, 0, 1);
        add(0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 1, 1, 8'h03, 1, 0, 1);
        add(0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 1, 8'h04, 1, 0, 1);
        add(0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 8'h04, 1, 0, 1);
        add(0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 8'h04, 1, 0, 1);
        add(0, 1, 8'h20, 0, 8'h00, 0, 0,  1, 0, 0, 8'h04, 1, 0, 1);
        add(0, 1, 8'h21, 0, 8'h00, 0, 0,  2, 0, 0, 8'h04, 1, 0, 1);
        add(0, 1, 8'h22, 0, 8'h00, 1, 0,  2, 0, 1, 8'h20, 0, 0, 1);
        add(0, 0, 8'h00, 1, 8'h30, 0, 0,  2, 1, 0, 8'h20, 0, 0, 1);
        add(0, 0, 8'h00, 0, 8'h00, 1, 1,  1, 1, 1, 8'h21, 0, 0, 1);
        add(0, 0, 8'h00, 0, 8'h00, 1, 1,  0, 1, 1, 8'h22, 0, 0, 1);
        add(1, 1, 8'h40, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h50, 0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h51, 0, 8'h00, 0, 0,  2, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h52, 0, 8'h00, 0, 0,  3, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h53, 0, 8'h00, 0, 0,  4, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h54, 0, 8'h00, 1, 0,  3, 0, 1, 8'h50, 0, 1, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0, 0,  3, 0, 0, 8'h50, 0, 1, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1, 0,  2, 0, 1, 8'h51, 0, 1, 0);

        drive(1, 0, 8'h00, 0, 8'h00, 0, 0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].we0, vecs[i].d0, vecs[i].we1, vecs[i].d1,
                  vecs[i].g0, vecs[i].g1);
            @(posedge clk); #1;
            chk($sformatf("v%0d count_0", i), 32'(count_0), 32'(vecs[i].c0));
            chk($sformatf("v%0d count_1", i), 32'(count_1), 32'(vecs[i].c1));
            chk($sformatf("v%0d req_0", i), 32'(req_0), 32'(vecs[i].c0 != 0));
            chk($sformatf("v%0d req_1", i), 32'(req_1), 32'(vecs[i].c1 != 0));
            chk($sformatf("v%0d full_0", i), 32'(full_0), 32'(vecs[i].c0 == 4));
            chk($sformatf("v%0d full_1", i), 32'(full_1), 32'(vecs[i].c1 == 4));
            chk($sformatf("v%0d ovf_0", i), 32'(ovf_0), 32'(vecs[i].ovf0));
            chk($sformatf("v%0d ovf_1", i), 32'(ovf_1), 32'(vecs[i].ovf1));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].v));
            chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].od));
            chk($sformatf("v%0d out_src", i), 32'(out_src), 32'(vecs[i].os));
        end

        // Pointer wrap: ten words streamed through FIFO 0 with one-cycle residency.
        drive(1, 0, 8'h00, 0, 8'h00, 0, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 8'(8'h10 + i), 0, 8'h00, (i > 0), 0);
            @(posedge clk); #1;
            chk($sformatf("wrap%0d count_0", i), 32'(count_0), 32'd1);
            chk($sformatf("wrap%0d out_valid", i), 32'(out_valid), 32'(i > 0));
            if (i > 0) begin
                chk($sformatf("wrap%0d out_data", i), 32'(out_data), 32'(8'h10 + i - 1));
                chk($sformatf("wrap%0d out_src", i), 32'(out_src), 32'd0);
            end
        end
        drive(0, 0, 8'h00, 0, 8'h00, 1, 0);
        @(posedge clk); #1;
        chk("wrap_last out_data", 32'(out_data), 32'h19);
        chk("wrap_last out_valid", 32'(out_valid), 32'd1);
        chk("wrap_last count_0", 32'(count_0), 32'd0);
        @(posedge clk); #1;
        chk("wrap_idle out_valid", 32'(out_valid), 32'd0);
        chk("wrap_idle req_0", 32'(req_0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
